// File: rtl/usb_tx_sequencer.sv
// USB full-speed transmit sequencer: SYNC, LSB-first payload with NRZI and bit stuffing, then EOP.
// Line updates happen only on bit_strobe; the bit timer is held in reset while idle.
module usb_tx_sequencer #(
    parameter logic [7:0] SYNC_PATTERN = 8'h80,
    parameter int         STUFF_LEN    = 6,
    parameter int         EOP_SE0_BITS = 2
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       bit_strobe,
    output logic       timer_rst_n,
    input  logic [7:0] tx_data,
    input  logic       tx_valid,
    input  logic       tx_last,
    output logic       tx_ready,
    output logic       d_plus,
    output logic       d_minus,
    output logic       busy,
    output logic       done,
    output logic       underrun
);

    typedef enum logic [2:0] {
        IDLE,
        SYNC,
        DATA,
        STUFF,
        EOP_SE0,
        EOP_J
    } state_t;

    localparam logic [2:0] STUFF_MAX = 3'(STUFF_LEN);
    localparam logic [2:0] SE0_LAST  = 3'(EOP_SE0_BITS - 1);

    state_t     state, state_n;
    logic [7:0] hold, hold_n;
    logic       hold_full, hold_full_n;
    logic       last_taken, last_taken_n;
    logic [7:0] shift_reg, shift_n;
    logic [2:0] bit_cnt, bit_cnt_n;
    logic [2:0] ones_cnt, ones_n;
    logic       end_pending, end_pending_n;
    logic       d_plus_n, d_minus_n;
    logic       tx_ready_n, busy_n, done_n, underrun_n, timer_rst_n_n;
    logic       accept;
    logic       cur_bit;

    assign accept = tx_valid && tx_ready;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state       <= IDLE;
            hold        <= 8'h00;
            hold_full   <= 1'b0;
            last_taken  <= 1'b0;
            shift_reg   <= 8'h00;
            bit_cnt     <= 3'd0;
            ones_cnt    <= 3'd0;
            end_pending <= 1'b0;
            d_plus      <= 1'b1;
            d_minus     <= 1'b0;
            tx_ready    <= 1'b1;
            busy        <= 1'b0;
            done        <= 1'b0;
            underrun    <= 1'b0;
            timer_rst_n <= 1'b0;
        end else begin
            state       <= state_n;
            hold        <= hold_n;
            hold_full   <= hold_full_n;
            last_taken  <= last_taken_n;
            shift_reg   <= shift_n;
            bit_cnt     <= bit_cnt_n;
            ones_cnt    <= ones_n;
            end_pending <= end_pending_n;
            d_plus      <= d_plus_n;
            d_minus     <= d_minus_n;
            tx_ready    <= tx_ready_n;
            busy        <= busy_n;
            done        <= done_n;
            underrun    <= underrun_n;
            timer_rst_n <= timer_rst_n_n;
        end
    end

    always_comb begin
        state_n       = state;
        hold_n        = hold;
        hold_full_n   = hold_full;
        last_taken_n  = last_taken;
        shift_n       = shift_reg;
        bit_cnt_n     = bit_cnt;
        ones_n        = ones_cnt;
        end_pending_n = end_pending;
        d_plus_n      = d_plus;
        d_minus_n     = d_minus;
        done_n        = 1'b0;
        underrun_n    = 1'b0;
        cur_bit       = 1'b0;

        if (accept) begin
            hold_n      = tx_data;
            hold_full_n = 1'b1;
            if (tx_last) begin
                last_taken_n = 1'b1;
            end
        end

        case (state)
            IDLE: begin
                if (accept) begin
                    state_n       = SYNC;
                    bit_cnt_n     = 3'd0;
                    ones_n        = 3'd0;
                    end_pending_n = 1'b0;
                end
            end
            SYNC, DATA: begin
                if (bit_strobe) begin
                    cur_bit = (state == SYNC) ? SYNC_PATTERN[bit_cnt] : shift_reg[0];
                    if (!cur_bit) begin
                        d_plus_n  = ~d_plus;
                        d_minus_n = ~d_minus;
                    end
                    ones_n    = cur_bit ? ones_cnt + 3'd1 : 3'd0;
                    shift_n   = {1'b0, shift_reg[7:1]};
                    bit_cnt_n = bit_cnt + 3'd1;
                    // Byte boundary: refill from hold, bypass a same-cycle byte, or finish.
                    if (bit_cnt == 3'd7) begin
                        if (hold_full) begin
                            shift_n     = hold;
                            hold_full_n = 1'b0;
                            state_n     = DATA;
                        end else if (accept) begin
                            shift_n     = tx_data;
                            hold_full_n = 1'b0;
                            state_n     = DATA;
                        end else if (last_taken) begin
                            end_pending_n = 1'b1;
                            state_n       = EOP_SE0;
                        end else begin
                            underrun_n = 1'b1;
                            state_n    = EOP_SE0;
                        end
                    end
                    if (ones_n == STUFF_MAX && !underrun_n) begin
                        state_n = STUFF;
                    end
                end
            end
            STUFF: begin
                if (bit_strobe) begin
                    d_plus_n  = ~d_plus;
                    d_minus_n = ~d_minus;
                    ones_n    = 3'd0;
                    state_n   = end_pending ? EOP_SE0 : DATA;
                end
            end
            EOP_SE0: begin
                if (bit_strobe) begin
                    d_plus_n  = 1'b0;
                    d_minus_n = 1'b0;
                    if (bit_cnt == SE0_LAST) begin
                        bit_cnt_n = 3'd0;
                        state_n   = EOP_J;
                    end else begin
                        bit_cnt_n = bit_cnt + 3'd1;
                    end
                end
            end
            EOP_J: begin
                if (bit_strobe) begin
                    d_plus_n      = 1'b1;
                    d_minus_n     = 1'b0;
                    state_n       = IDLE;
                    done_n        = 1'b1;
                    last_taken_n  = 1'b0;
                    end_pending_n = 1'b0;
                    hold_full_n   = 1'b0;
                end
            end
            default: begin
                state_n = IDLE;
            end
        endcase

        busy_n        = (state_n != IDLE);
        timer_rst_n_n = (state_n != IDLE);
        tx_ready_n    = !hold_full_n && !last_taken_n &&
                        (state_n inside {IDLE, SYNC, DATA, STUFF});
    end

endmodule

// File: tb/tb_usb_tx_sequencer.sv
// Directed bench for usb_tx_sequencer: a 4-cycle bit timer model, a byte source, and line capture
// on every strobe compared against hand-encoded J/K/SE0 sequences.
module tb_usb_tx_sequencer;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       bit_strobe = 1'b0;
    logic       timer_rst_n;
    logic [7:0] tx_data = 8'h00;
    logic       tx_valid = 1'b0;
    logic       tx_last = 1'b0;
    logic       tx_ready;
    logic       d_plus;
    logic       d_minus;
    logic       busy;
    logic       done;
    logic       underrun;

    always #5 clk = ~clk;

    usb_tx_sequencer dut (
        .clk        (clk),
        .rst        (rst),
        .bit_strobe (bit_strobe),
        .timer_rst_n(timer_rst_n),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_last    (tx_last),
        .tx_ready   (tx_ready),
        .d_plus     (d_plus),
        .d_minus    (d_minus),
        .busy       (busy),
        .done       (done),
        .underrun   (underrun)
    );

    int         checks = 0;
    int         errors = 0;
    logic [7:0] pkt_data[4];
    logic       pkt_last[4];
    int         pkt_n = 0;
    int         idx = 0;
    int         withhold_idx = -1;
    int         rcnt = 0;
    int         tcnt = 0;
    bit         b2b = 1'b0;
    logic [1:0] line_q[$];
    int         done_cnt = 0;
    int         underrun_cnt = 0;
    int         underrun_at = -1;

    task automatic check_output(input string tag, input logic [7:0] obs, input logic [7:0] want);
        checks++;
        assert (obs === want)
        else begin
            errors++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, want);
        end
    endtask

    task automatic drive_inputs();
        if (idx < pkt_n && idx != withhold_idx && (idx == 0 || b2b || rcnt >= 2)) begin
            tx_valid = 1'b1;
            tx_data  = pkt_data[idx];
            tx_last  = pkt_last[idx];
        end else begin
            tx_valid = 1'b0;
            tx_data  = 8'h00;
            tx_last  = 1'b0;
        end
    endtask

    // One clock: capture outputs at the negedge, then drive the byte source and the bit timer model.
    task automatic apply_stimulus();
        logic acc;
        logic strb;
        acc  = tx_valid && tx_ready;
        strb = bit_strobe;
        @(negedge clk);
        if (strb) line_q.push_back({d_plus, d_minus});
        if (done) done_cnt++;
        if (underrun) begin
            underrun_cnt++;
            underrun_at = line_q.size();
        end
        if (acc) begin
            idx++;
            rcnt = 0;
        end else if (tx_ready && !tx_valid) begin
            rcnt++;
        end
        drive_inputs();
        if (!timer_rst_n) begin
            tcnt       = 0;
            bit_strobe = 1'b0;
        end else begin
            tcnt++;
            bit_strobe = (tcnt % 4 == 0);
        end
    endtask

    task automatic start_packet();
        line_q.delete();
        done_cnt     = 0;
        underrun_cnt = 0;
        underrun_at  = -1;
        idx          = 0;
        rcnt         = 0;
        drive_inputs();
    endtask

    task automatic run_packet(input int stop_lines);
        int n;
        n = 0;
        while (done_cnt == 0 && line_q.size() != stop_lines && n < 2000) begin
            apply_stimulus();
            n++;
        end
        check_output("timeout", 8'(n >= 2000), 8'd0);
    endtask

    task automatic check_line(input string tag, input string want);
        check_output({tag, "_len"}, 8'(line_q.size()), 8'(want.len()));
        for (int i = 0; i < want.len() && i < line_q.size(); i++) begin
            logic [1:0] e;
            e = (want[i] == "J") ? 2'b10 : (want[i] == "K") ? 2'b01 : 2'b00;
            check_output($sformatf("%s_bit%0d", tag, i), {6'd0, line_q[i]}, {6'd0, e});
        end
    endtask

    initial begin
        string sync_s;
        string exp00;
        string expff;
        string exp7e;
        sync_s = "KJKJKJKK";
        exp00  = {sync_s, "JKJKJKJK", "00J"};
        expff  = {sync_s, "KKKKKJJJJ", "00J"};
        exp7e  = {sync_s, "JJJJJJJKJ", "JJJJJJKKK", "00J"};

        $display("[TB] reset state");
        repeat (3) @(negedge clk);
        check_output("rst_dplus", {7'd0, d_plus}, 8'd1);
        check_output("rst_dminus", {7'd0, d_minus}, 8'd0);
        check_output("rst_timer", {7'd0, timer_rst_n}, 8'd0);
        check_output("rst_ready", {7'd0, tx_ready}, 8'd1);
        check_output("rst_busy", {7'd0, busy}, 8'd0);
        check_output("rst_done", {7'd0, done}, 8'd0);
        check_output("rst_underrun", {7'd0, underrun}, 8'd0);
        rst = 1'b1;
        apply_stimulus();
        apply_stimulus();

        $display("[TB] single byte 00");
        pkt_data[0] = 8'h00; pkt_last[0] = 1'b1; pkt_n = 1;
        start_packet();
        apply_stimulus();
        check_output("p00_busy_start", {7'd0, busy}, 8'd1);
        check_output("p00_timer_start", {7'd0, timer_rst_n}, 8'd1);
        check_output("p00_ready_start", {7'd0, tx_ready}, 8'd0);
        run_packet(-1);
        check_output("p00_done", {7'd0, done}, 8'd1);
        check_output("p00_busy_end", {7'd0, busy}, 8'd0);
        check_output("p00_timer_end", {7'd0, timer_rst_n}, 8'd0);
        check_output("p00_ready_end", {7'd0, tx_ready}, 8'd1);
        check_line("p00", exp00);
        repeat (4) apply_stimulus();
        check_output("p00_done_cnt", 8'(done_cnt), 8'd1);
        check_output("p00_underrun_cnt", 8'(underrun_cnt), 8'd0);

        $display("[TB] single byte FF");
        pkt_data[0] = 8'hFF; pkt_last[0] = 1'b1; pkt_n = 1;
        start_packet();
        run_packet(-1);
        check_line("pff", expff);
        check_output("pff_done_cnt", 8'(done_cnt), 8'd1);

        $display("[TB] two bytes 7E FF");
        pkt_data[0] = 8'h7E; pkt_last[0] = 1'b0;
        pkt_data[1] = 8'hFF; pkt_last[1] = 1'b1; pkt_n = 2;
        start_packet();
        run_packet(-1);
        check_line("p7e", exp7e);
        check_output("p7e_underrun_cnt", 8'(underrun_cnt), 8'd0);
        check_output("p7e_done_cnt", 8'(done_cnt), 8'd1);
        check_output("p7e_bytes_taken", 8'(idx), 8'd2);

        $display("[TB] underrun");
        pkt_data[0] = 8'h00; pkt_last[0] = 1'b0;
        pkt_data[1] = 8'h55; pkt_last[1] = 1'b1; pkt_n = 2; withhold_idx = 1;
        start_packet();
        run_packet(-1);
        check_output("ur_count", 8'(underrun_cnt), 8'd1);
        check_output("ur_position", 8'(underrun_at), 8'd16);
        check_output("ur_done", {7'd0, done}, 8'd1);
        check_output("ur_busy", {7'd0, busy}, 8'd0);
        check_line("ur", exp00);
        withhold_idx = -1; pkt_n = 0;
        drive_inputs();
        apply_stimulus();

        $display("[TB] reset mid-packet");
        pkt_data[0] = 8'h00; pkt_last[0] = 1'b1; pkt_n = 1;
        start_packet();
        run_packet(11);
        rst = 1'b0;
        pkt_n = 0;
        drive_inputs();
        @(negedge clk);
        check_output("mid_rst_dplus", {7'd0, d_plus}, 8'd1);
        check_output("mid_rst_dminus", {7'd0, d_minus}, 8'd0);
        check_output("mid_rst_timer", {7'd0, timer_rst_n}, 8'd0);
        check_output("mid_rst_busy", {7'd0, busy}, 8'd0);
        check_output("mid_rst_ready", {7'd0, tx_ready}, 8'd1);
        rst        = 1'b1;
        tcnt       = 0;
        bit_strobe = 1'b0;
        apply_stimulus();
        pkt_data[0] = 8'hFF; pkt_last[0] = 1'b1; pkt_n = 1;
        start_packet();
        run_packet(-1);
        check_line("after_rst", expff);
        check_output("after_rst_done_cnt", 8'(done_cnt), 8'd1);

        $display("[TB] back-to-back packets");
        pkt_data[0] = 8'h00; pkt_last[0] = 1'b1;
        pkt_data[1] = 8'h00; pkt_last[1] = 1'b1; pkt_n = 2; b2b = 1'b1;
        start_packet();
        run_packet(-1);
        check_output("b2b_ready_at_done", {7'd0, tx_ready}, 8'd1);
        check_output("b2b_busy_at_done", {7'd0, busy}, 8'd0);
        check_line("b2b_p1", exp00);
        line_q.delete();
        done_cnt = 0;
        apply_stimulus();
        check_output("b2b_taken", 8'(idx), 8'd2);
        check_output("b2b_busy_restart", {7'd0, busy}, 8'd1);
        check_output("b2b_timer_restart", {7'd0, timer_rst_n}, 8'd1);
        run_packet(-1);
        check_line("b2b_p2", exp00);
        check_output("b2b_done_cnt", 8'(done_cnt), 8'd1);
        b2b = 1'b0;

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
